// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and helpers for the framed UART transmitter.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;
    localparam logic [1:0] PAR_MARK = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Clocks per bit, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned freq, input int unsigned rate);
        return (freq + rate / 2) / rate;
    endfunction

    // Parity bit for a payload whose XOR reduction is data_xor.
    function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
        logic bit_val;
        bit_val = 1'b1;
        case (mode)
            PAR_EVEN: bit_val = data_xor;
            PAR_ODD:  bit_val = ~data_xor;
            default:  bit_val = 1'b1;
        endcase
        return bit_val;
    endfunction

endpackage

// File: rtl/uart_framed_tx_if.sv
// Producer-side write bus of the framed UART transmitter.
interface uart_framed_tx_if #(
    parameter int unsigned data_bits  = 8,
    parameter int unsigned fifo_depth = 16
);
    localparam int unsigned LEVEL_W = $clog2(fifo_depth) + 1;

    logic                 write;
    logic [data_bits-1:0] write_data;
    logic                 can_write;
    logic [LEVEL_W-1:0]   level;
    logic                 overflow;

    modport master (
        output write, write_data,
        input  can_write, level, overflow
    );

    modport slave (
        input  write, write_data,
        output can_write, level, overflow
    );
endinterface

// File: rtl/uart_framed_tx_sync_fifo.sv
// Single-clock FIFO with show-ahead read port and full-width occupancy count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   write,
    input  logic [WIDTH-1:0]       write_data,
    input  logic                   read,
    output logic [WIDTH-1:0]       read_data_c,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;
    logic [LW-1:0]    level_next_c;

    // A write while full is dropped even if a pop happens in the same cycle.
    assign do_push_c   = write && !full;
    assign do_pop_c    = read && !empty;
    assign read_data_c = mem[rd_ptr];

    // Next occupancy from push/pop combination.
    always_comb begin
        level_next_c = level;
        if (do_push_c && !do_pop_c) begin
            level_next_c = level + LW'(1);
        end else if (!do_push_c && do_pop_c) begin
            level_next_c = level - LW'(1);
        end
    end

    // Pointers, count, flags and overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level    <= level_next_c;
            full     <= (level_next_c == LW'(DEPTH));
            empty    <= (level_next_c == '0);
            overflow <= write && full;
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= write_data;
        end
    end

endmodule

// File: rtl/uart_framed_tx.sv
// Buffered UART transmitter: write FIFO feeding a start/data/parity/stop serialiser.
module uart_framed_tx
    import uart_pkg::*;
#(
    parameter int unsigned clk_freq   = 160_000_000,
    parameter int unsigned baud_rate  = 115_200,
    parameter int unsigned data_bits  = 8,
    parameter int unsigned fifo_depth = 16
) (
    input  logic             clk,
    input  logic             rst,
    uart_framed_tx_if.slave  bus,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    output logic             busy,
    output logic             txd
);
    localparam int unsigned DIV   = baud_div(clk_freq, baud_rate);
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned BIT_W = $clog2(data_bits + 1);

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_c;
    logic [data_bits-1:0] head_c;

    tx_state_t            state;
    tx_state_t            state_next_c;
    logic [CNT_W-1:0]     baud_cnt;
    logic [CNT_W-1:0]     baud_cnt_next_c;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_next_c;
    logic [data_bits-1:0] shift;
    logic [data_bits-1:0] shift_next_c;
    logic                 par_q;
    logic                 par_next_c;
    logic                 par_en_q;
    logic                 par_en_next_c;
    logic                 two_stop_q;
    logic                 two_stop_next_c;
    logic                 txd_next_c;
    logic                 busy_next_c;
    logic                 bit_end_c;

    sync_fifo #(
        .WIDTH (data_bits),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .write       (bus.write),
        .write_data  (bus.write_data),
        .read        (pop_c),
        .read_data_c (head_c),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .level       (bus.level),
        .overflow    (bus.overflow)
    );

    assign bus.can_write = ~fifo_full;
    assign bit_end_c     = (baud_cnt == CNT_W'(DIV - 1));

    // Serialiser next state; txd/busy are derived from the next state so they register in step with it.
    always_comb begin
        state_next_c    = state;
        baud_cnt_next_c = baud_cnt;
        bit_cnt_next_c  = bit_cnt;
        shift_next_c    = shift;
        par_next_c      = par_q;
        par_en_next_c   = par_en_q;
        two_stop_next_c = two_stop_q;
        pop_c           = 1'b0;
        txd_next_c      = 1'b1;
        busy_next_c     = 1'b0;

        if (state != ST_IDLE) begin
            baud_cnt_next_c = bit_end_c ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                baud_cnt_next_c = '0;
                bit_cnt_next_c  = '0;
                if (!fifo_empty) begin
                    pop_c           = 1'b1;
                    shift_next_c    = head_c;
                    par_next_c      = parity_bit(parity_mode, ^head_c);
                    par_en_next_c   = (parity_mode != PAR_NONE);
                    two_stop_next_c = two_stop;
                    state_next_c    = ST_START;
                end
            end
            ST_START: begin
                if (bit_end_c) begin
                    state_next_c = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end_c) begin
                    shift_next_c = shift >> 1;
                    if (bit_cnt == BIT_W'(data_bits - 1)) begin
                        bit_cnt_next_c = '0;
                        state_next_c   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_next_c = bit_cnt + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end_c) begin
                    state_next_c = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end_c) begin
                    if (bit_cnt == BIT_W'(two_stop_q)) begin
                        bit_cnt_next_c = '0;
                        state_next_c   = ST_IDLE;
                    end else begin
                        bit_cnt_next_c = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next_c = ST_IDLE;
            end
        endcase

        case (state_next_c)
            ST_START:  txd_next_c = 1'b0;
            ST_DATA:   txd_next_c = shift_next_c[0];
            ST_PARITY: txd_next_c = par_next_c;
            default:   txd_next_c = 1'b1;
        endcase
        busy_next_c = (state_next_c != ST_IDLE);
    end

    // Serialiser state and registered line outputs; reset forces the line idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
            txd        <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_next_c;
            baud_cnt   <= baud_cnt_next_c;
            bit_cnt    <= bit_cnt_next_c;
            shift      <= shift_next_c;
            par_q      <= par_next_c;
            par_en_q   <= par_en_next_c;
            two_stop_q <= two_stop_next_c;
            txd        <= txd_next_c;
            busy       <= busy_next_c;
        end
    end

endmodule
